// File: rtl/btt_pkg.sv
// Shared types and default sizing for the branch-target table.
// The FSM encoding and the reset-time default target live here so every file agrees on them.
package btt_pkg;

  typedef enum logic {
    BTT_INIT  = 1'b0,
    BTT_READY = 1'b1
  } btt_state_t;

  localparam int unsigned BTT_ADDR_W   = 5;
  localparam int unsigned BTT_TARGET_W = 16;
  localparam logic [BTT_TARGET_W-1:0] BTT_DEFAULT_TARGET = 16'h0000;

endpackage

// File: rtl/btt_target_calc.sv
// Resolves a table entry into a fetch target: absolute entries pass through,
// relative entries add a signed offset to the lookup PC with modular wrap.
module btt_target_calc
  import btt_pkg::*;
#(
  parameter int unsigned TARGET_W = BTT_TARGET_W
) (
  input  logic                rel_i,
  input  logic [TARGET_W-1:0] base_i,
  input  logic [TARGET_W-1:0] pc_i,
  output logic [TARGET_W-1:0] target_o
);

  // Two's-complement add truncated to TARGET_W; the carry out is deliberately dropped.
  function automatic logic [TARGET_W-1:0] wrap_add(
    input logic        [TARGET_W-1:0] pc,
    input logic signed [TARGET_W-1:0] off
  );
    return pc + $unsigned(off);
  endfunction

  logic signed [TARGET_W-1:0] offset;

  assign offset   = $signed(base_i);
  assign target_o = rel_i ? wrap_add(pc_i, offset) : base_i;

endmodule

// File: rtl/branch_target_table.sv
// Writable branch-pointer -> PC-target lookup with a registered, one-cycle read,
// a write-first bypass, and a self-clearing init sweep after reset or on request.
module branch_target_table
  import btt_pkg::*;
#(
  parameter int unsigned          ADDR_W         = BTT_ADDR_W,
  parameter int unsigned          TARGET_W       = BTT_TARGET_W,
  parameter logic [TARGET_W-1:0]  DEFAULT_TARGET = BTT_DEFAULT_TARGET
) (
  input  logic                Clk,
  input  logic                Reset,
  input  logic                Init_req,
  output logic                Busy,
  input  logic                Wr_en,
  input  logic [ADDR_W-1:0]   Wr_addr,
  input  logic [TARGET_W-1:0] Wr_data,
  input  logic                Wr_rel,
  input  logic                Inv_en,
  input  logic [ADDR_W-1:0]   Inv_addr,
  input  logic                Rd_en,
  input  logic [ADDR_W-1:0]   Rd_addr,
  input  logic [TARGET_W-1:0] Rd_pc,
  output logic [TARGET_W-1:0] Target,
  output logic                Target_vld,
  output logic                Miss
);

  localparam int unsigned ENTRIES = 2 ** ADDR_W;

  btt_state_t          state_q, state_d;
  logic [ADDR_W-1:0]   ctr_q, ctr_d;
  logic [ENTRIES-1:0]  valid_q, valid_d;
  logic [TARGET_W-1:0] data_q [ENTRIES];
  logic [ENTRIES-1:0]  rel_q;

  logic [TARGET_W-1:0] target_q, target_d;
  logic                vld_q, vld_d;
  logic                miss_q, miss_d;

  logic                accept;
  logic                rd_fire;
  logic                rd_bypass;
  logic                rd_hit;
  logic                rd_rel;
  logic [TARGET_W-1:0] rd_base;
  logic [TARGET_W-1:0] rd_target;

  // Only READY accepts traffic; anything arriving while sweeping is dropped.
  assign accept  = (state_q == BTT_READY);
  assign rd_fire = accept && Rd_en;

  always_comb begin
    state_d = state_q;
    ctr_d   = ctr_q;
    unique case (state_q)
      BTT_INIT: begin
        if (Init_req) begin
          ctr_d = '0;
        end else if (&ctr_q) begin
          state_d = BTT_READY;
          ctr_d   = '0;
        end else begin
          ctr_d = ctr_q + 1'b1;
        end
      end
      BTT_READY: begin
        if (Init_req) begin
          state_d = BTT_INIT;
          ctr_d   = '0;
        end
      end
      default: begin
        state_d = BTT_INIT;
        ctr_d   = '0;
      end
    endcase
  end

  // Write is applied after invalidate so a same-address write wins.
  always_comb begin
    valid_d = valid_q;
    if (!accept) begin
      valid_d[ctr_q] = 1'b0;
    end else begin
      if (Inv_en) valid_d[Inv_addr] = 1'b0;
      if (Wr_en)  valid_d[Wr_addr]  = 1'b1;
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q <= BTT_INIT;
      ctr_q   <= '0;
      valid_q <= '0;
    end else begin
      state_q <= state_d;
      ctr_q   <= ctr_d;
      valid_q <= valid_d;
    end
  end

  // Payload storage carries no reset; an entry is meaningless until its valid bit is set.
  always_ff @(posedge Clk) begin
    if (!accept) begin
      data_q[ctr_q] <= DEFAULT_TARGET;
      rel_q[ctr_q]  <= 1'b0;
    end else if (Wr_en) begin
      data_q[Wr_addr] <= Wr_data;
      rel_q[Wr_addr]  <= Wr_rel;
    end
  end

  // A same-cycle write to the looked-up pointer is forwarded; a same-cycle
  // invalidate is not, since valid_q still holds the pre-invalidate bit.
  always_comb begin
    rd_bypass = Wr_en && (Wr_addr == Rd_addr);
    rd_base   = rd_bypass ? Wr_data : data_q[Rd_addr];
    rd_rel    = rd_bypass ? Wr_rel  : rel_q[Rd_addr];
    rd_hit    = rd_bypass || valid_q[Rd_addr];
  end

  btt_target_calc #(
    .TARGET_W (TARGET_W)
  ) u_calc (
    .rel_i    (rd_rel),
    .base_i   (rd_base),
    .pc_i     (Rd_pc),
    .target_o (rd_target)
  );

  always_comb begin
    target_d = target_q;
    miss_d   = miss_q;
    vld_d    = rd_fire;
    if (rd_fire) begin
      target_d = rd_hit ? rd_target : DEFAULT_TARGET;
      miss_d   = !rd_hit;
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      target_q <= '0;
      vld_q    <= 1'b0;
      miss_q   <= 1'b0;
    end else begin
      target_q <= target_d;
      vld_q    <= vld_d;
      miss_q   <= miss_d;
    end
  end

  assign Busy       = (state_q == BTT_INIT);
  assign Target     = target_q;
  assign Target_vld = vld_q;
  assign Miss       = miss_q;

endmodule
